stream_source_fifo: RTL
=======================

// Module: stream_source_fifo
// PURPOSE
//  Transmit-side counterpart of the stream consumer: buffers bytes pushed by a
//  testbench/driver write port and presents them on a valid/ready byte stream.
//  Sits in front of any stream_in_valid/stream_in_ready/stream_in_data sink in
//  the test designs, so cocotb benches can exercise backpressure with a real source.
// PARAMETERS
//  DEPTH      16   FIFO entries; power of two, >= 2
//  DATA_W     8    stream/write data width
//  CNT_W      16   width of transfer counter tx_count
// PORTS
//  clk               in   1                  rising-edge clock, single domain
//  reset             in   1                  asynchronous, active-high reset
//  wr_en             in   1                  push wr_data this cycle
//  wr_data           in   DATA_W             data to push
//  wr_full           out  1                  FIFO holds DEPTH entries
//  stream_out_valid  out  1                  stream_out_data holds a valid byte
//  stream_out_ready  in   1                  sink accepts byte this cycle
//  stream_out_data   out  DATA_W             head-of-FIFO byte
//  level             out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  overflow          out  1                  sticky: a push was dropped
//  tx_count          out  CNT_W              completed stream transfers
// BEHAVIOUR
//  - Reset (async assert, sync-released use): valid=0, data=0, wr_full=0, level=0,
//    overflow=0, tx_count=0; pointers cleared; storage contents not cleared.
//  - Reset mid-operation: all queued bytes discarded; valid drops immediately.
//  - Storage: DEPTH x DATA_W array; rd/wr pointers $clog2(DEPTH)+1 bits, wrap
//    modulo 2*DEPTH; full = MSBs differ & rest equal; empty = pointers equal.
//  - Output is first-word fall-through: stream_out_valid = (level != 0);
//    stream_out_data = mem[rd_ptr] when valid, else 0.
//  - Latency: push at edge N into empty FIFO -> valid=1 and data visible after
//    edge N (same cycle as level becomes 1).
//  - Transfer = stream_out_valid & stream_out_ready at rising edge; rd_ptr++,
//    tx_count++ (wraps 2^CNT_W-1 -> 0 silently).
//  - While valid & !ready: valid and data held stable (AXI-style rule).
//  - Push accepted when wr_en & (!wr_full | transfer). Full + push + transfer in
//    same cycle: push accepted, level stays DEPTH.
//  - wr_en & wr_full & !transfer: byte dropped, pointers unchanged, overflow=1
//    from next cycle until reset.
//  - Empty + push: accepted; no read possible same cycle (valid low).
//  - level: +1 push only, -1 transfer only, unchanged for both or neither.
//  - wr_full = (level == DEPTH), combinational from pointers.
// TESTING
//  1 reset, push 0xA5 with ready=1 -> valid next cycle, data=0xA5, tx_count=1
//    after following edge, level back to 0.
//  2 ready=0, push 0x01..0x10 (DEPTH=16) -> wr_full=1, level=16, data held
//    0x01; push 0x11 -> overflow=1, then drain: 0x01..0x10 in order, no 0x11.
//  3 full FIFO, ready=1 and push 0x77 same cycle -> level stays 16; 0x77
//    emerges 16th after the 0x01 head, overflow stays 0.
//  4 random ready (50%), 1000 pushes with wr_en gated by !wr_full -> output
//    sequence equals input, data stable while valid&!ready, tx_count=1000.
//  5 assert reset with level=5 mid-stream -> valid=0, level=0 within same
//    cycle; after release push 0x3C -> next output is 0x3C.
//  6 preload tx_count via 65535 transfers, one more -> tx_count wraps to 0.

Source files
------------

// File: rtl/stream_source_fifo.sv
// rtl/stream_source_fifo.sv - byte FIFO driven by a write port, drained as a first-word fall-through valid/ready stream
module stream_source_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_full,
  output logic                       stream_out_valid,
  input  logic                       stream_out_ready,
  output logic [DATA_W-1:0]          stream_out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           tx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              transfer;
  logic              push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign wr_full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign stream_out_valid = (wr_ptr != rd_ptr);
  assign level            = wr_ptr - rd_ptr;
  assign stream_out_data  = stream_out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  assign transfer = stream_out_valid && stream_out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = wr_en && (!wr_full || transfer);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      tx_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (transfer) begin
        rd_ptr   <= rd_ptr + 1'b1;
        tx_count <= tx_count + 1'b1;
      end
      if (wr_en && wr_full && !transfer) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
